// File: rtl/npc_sched_pkg.sv
// Shared definitions for the next-PC scheduler:
// boot/exception vectors, FSM states, redirect priorities.
package npc_sched_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_PEND  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_JMP  = 2'd1,
        P_BR   = 2'd2,
        P_ERET = 2'd3
    } prio_e;

    // Exceptions outrank every encoded redirect priority
    function automatic logic [2:0] rank(input logic exc, input prio_e p);
        return exc ? 3'd4 : {1'b0, p};
    endfunction

endpackage

// File: rtl/npc_prio_sel.sv
// Priority select between live redirect requests and the pending buffer,
// with target alignment check and exception-vector substitution.
module npc_prio_sel #(
    parameter logic [31:0] EXC_ADDR = npc_sched_pkg::EXC_VEC
) (
    input  logic                 exc_req,
    input  logic                 eret_req,
    input  logic [31:0]          epc_i,
    input  logic                 br_req,
    input  logic [31:0]          br_tgt,
    input  logic                 jmp_req,
    input  logic [31:0]          jmp_tgt,
    input  logic                 buf_exc,
    input  npc_sched_pkg::prio_e buf_prio,
    input  logic [31:0]          buf_tgt,
    output logic                 sel_vld,
    output logic                 sel_exc,
    output npc_sched_pkg::prio_e sel_prio,
    output logic [31:0]          sel_tgt,
    output logic [31:0]          npc_tgt,
    output logic                 take_exc,
    output logic                 misalign
);
    import npc_sched_pkg::*;

    prio_e       w_req_prio;
    logic [31:0] w_req_tgt;
    logic        w_take_req;

    always_comb begin
        w_req_prio = P_NONE;
        w_req_tgt  = '0;
        priority case (1'b1)
            exc_req:  w_req_tgt = EXC_ADDR;
            eret_req: begin w_req_prio = P_ERET; w_req_tgt = epc_i;   end
            br_req:   begin w_req_prio = P_BR;   w_req_tgt = br_tgt;  end
            jmp_req:  begin w_req_prio = P_JMP;  w_req_tgt = jmp_tgt; end
            default:  ;
        endcase
    end

    // Ties keep the buffered entry: only strictly higher requests replace it
    assign w_take_req = rank(exc_req, w_req_prio) > rank(buf_exc, buf_prio);

    assign sel_exc  = w_take_req ? exc_req    : buf_exc;
    assign sel_prio = w_take_req ? w_req_prio : buf_prio;
    assign sel_tgt  = w_take_req ? w_req_tgt  : buf_tgt;
    assign sel_vld  = sel_exc || (sel_prio != P_NONE);
    assign misalign = sel_vld && (sel_tgt[1:0] != 2'b00);
    assign npc_tgt  = misalign ? EXC_ADDR : sel_tgt;
    assign take_exc = sel_vld && (sel_exc || misalign);

endmodule

// File: rtl/npc_sched.sv
// Next-PC scheduler: boot vector, sequential PC, prioritized redirects
// with a one-entry buffer for redirects that arrive during a stall.
module npc_sched #(
    parameter logic [31:0] PC_RESET = npc_sched_pkg::PC_RESET,
    parameter logic [31:0] EXC_VEC  = npc_sched_pkg::EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        br_req,
    input  logic [31:0] br_tgt,
    input  logic        jmp_req,
    input  logic [31:0] jmp_tgt,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_i,
    output logic [31:0] npc_o,
    output logic        pc_we_o,
    output logic        flush_o,
    output logic        pend_o,
    output logic        misalign_o
);
    import npc_sched_pkg::*;

    state_e      r_state;
    state_e      w_nxt;
    logic        r_b_exc;
    prio_e       r_b_prio;
    logic [31:0] r_b_tgt;

    logic        w_sel_vld;
    logic        w_sel_exc;
    prio_e       w_sel_prio;
    logic [31:0] w_sel_tgt;
    logic [31:0] w_npc_tgt;
    logic        w_take_exc;
    logic        w_mis;
    logic        w_vld;
    logic        w_buf_ld;
    logic        w_buf_clr;
    logic [31:0] w_pc_inc;

    npc_prio_sel #(
        .EXC_ADDR (EXC_VEC)
    ) u_sel (
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc_i    (epc_i),
        .br_req   (br_req),
        .br_tgt   (br_tgt),
        .jmp_req  (jmp_req),
        .jmp_tgt  (jmp_tgt),
        .buf_exc  (r_b_exc),
        .buf_prio (r_b_prio),
        .buf_tgt  (r_b_tgt),
        .sel_vld  (w_sel_vld),
        .sel_exc  (w_sel_exc),
        .sel_prio (w_sel_prio),
        .sel_tgt  (w_sel_tgt),
        .npc_tgt  (w_npc_tgt),
        .take_exc (w_take_exc),
        .misalign (w_mis)
    );

    assign w_pc_inc  = pc_i + 32'd4;
    assign w_vld     = w_sel_vld && (r_state != S_BOOT);
    assign w_buf_ld  = w_vld && stall_i;
    assign w_buf_clr = (r_state == S_PEND) && !stall_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b_exc  <= 1'b0;
            r_b_prio <= P_NONE;
            r_b_tgt  <= '0;
        end else if (w_buf_ld) begin
            r_b_exc  <= w_sel_exc;
            r_b_prio <= w_sel_prio;
            r_b_tgt  <= w_sel_tgt;
        end else if (w_buf_clr) begin
            r_b_exc  <= 1'b0;
            r_b_prio <= P_NONE;
            r_b_tgt  <= '0;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_BOOT: w_nxt = S_RUN;
            S_RUN, S_FLUSH: begin
                if (w_vld && stall_i)
                    w_nxt = S_PEND;
                else if (w_vld && w_take_exc)
                    w_nxt = S_FLUSH;
                else
                    w_nxt = S_RUN;
            end
            S_PEND: begin
                if (!stall_i)
                    w_nxt = w_take_exc ? S_FLUSH : S_RUN;
            end
            default: w_nxt = S_BOOT;
        endcase
    end

    // Reset gates every output so nothing escapes while reset is held
    always_comb begin
        pc_we_o    = 1'b0;
        npc_o      = PC_RESET;
        flush_o    = 1'b0;
        pend_o     = 1'b0;
        misalign_o = 1'b0;
        if (reset) begin
            if (r_state == S_BOOT) begin
                pc_we_o = 1'b1;
            end else begin
                pc_we_o    = !stall_i;
                npc_o      = (w_vld && !stall_i) ? w_npc_tgt : w_pc_inc;
                flush_o    = w_vld && !stall_i && w_take_exc;
                pend_o     = (r_state == S_PEND);
                misalign_o = w_vld && w_mis;
            end
        end
    end

endmodule

// File: tb/tb_npc_sched.sv
// Directed self-checking bench for npc_sched.
module tb_npc_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        br_req;
    logic [31:0] br_tgt;
    logic        jmp_req;
    logic [31:0] jmp_tgt;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_i;
    logic [31:0] npc_o;
    logic        pc_we_o;
    logic        flush_o;
    logic        pend_o;
    logic        misalign_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    npc_sched dut (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall_i),
        .pc_i       (pc_i),
        .br_req     (br_req),
        .br_tgt     (br_tgt),
        .jmp_req    (jmp_req),
        .jmp_tgt    (jmp_tgt),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc_i      (epc_i),
        .npc_o      (npc_o),
        .pc_we_o    (pc_we_o),
        .flush_o    (flush_o),
        .pend_o     (pend_o),
        .misalign_o (misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] npc,
                           input logic we, input logic fl,
                           input logic pd, input logic ms);
        chk({tag, ".npc"}, npc_o, npc);
        chk({tag, ".we"}, {31'd0, pc_we_o}, {31'd0, we});
        chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
        chk({tag, ".pend"}, {31'd0, pend_o}, {31'd0, pd});
        chk({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, ms});
    endtask

    task automatic idle();
        br_req   = 1'b0;
        jmp_req  = 1'b0;
        exc_req  = 1'b0;
        eret_req = 1'b0;
        stall_i  = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        pc_i    = 32'h0;
        br_tgt  = 32'h0;
        jmp_tgt = 32'h0;
        epc_i   = 32'h0;
        idle();
        #2;
        chk_out("rst", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_out("boot", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        #1 chk_out("run_seq", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

        pc_i = 32'hFFFF_FFFC;
        #1 chk_out("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        pc_i = 32'h3008; stall_i = 1'b1;
        #1 chk_out("stall", 32'h300C, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        idle(); pc_i = 32'h3010; br_req = 1'b1; br_tgt = 32'h3040;
        #1 chk_out("br", 32'h3040, 1'b1, 1'b0, 1'b0, 1'b0);

        tick();
        exc_req = 1'b1; eret_req = 1'b1; epc_i = 32'h5000;
        #1 chk_out("prio_exc", 32'h4180, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle(); pc_i = 32'h4180;
        #1 chk_out("flush", 32'h4184, 1'b1, 1'b0, 1'b0, 1'b0);

        tick();
        eret_req = 1'b1; br_req = 1'b1; jmp_req = 1'b1;
        #1 chk_out("prio_eret", 32'h5000, 1'b1, 1'b0, 1'b0, 1'b0);
        eret_req = 1'b0; jmp_tgt = 32'h3100;
        #1 chk_out("prio_br", 32'h3040, 1'b1, 1'b0, 1'b0, 1'b0);
        br_req = 1'b0;
        #1 chk_out("jmp", 32'h3100, 1'b1, 1'b0, 1'b0, 1'b0);

        // jmp then br during a 3-cycle stall
        tick();
        idle(); pc_i = 32'h3010; stall_i = 1'b1; jmp_req = 1'b1;
        #1 chk_out("st1", 32'h3014, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        jmp_req = 1'b0; br_req = 1'b1; br_tgt = 32'h3200;
        #1 chk_out("st2", 32'h3014, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        br_req = 1'b0;
        #1 chk_out("st3", 32'h3014, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        stall_i = 1'b0;
        #1 chk_out("rel", 32'h3200, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        pc_i = 32'h3200;
        #1 chk_out("after_rel", 32'h3204, 1'b1, 1'b0, 1'b0, 1'b0);

        // buffered br overridden by exception
        stall_i = 1'b1; br_req = 1'b1;
        tick();
        br_req = 1'b0; exc_req = 1'b1;
        #1 chk_out("exc_st", 32'h3204, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        #1 chk_out("exc_rel", 32'h4180, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        pc_i = 32'h4180;
        #1 chk_out("exc_fl", 32'h4184, 1'b1, 1'b0, 1'b0, 1'b0);

        // lower-priority jump dropped while a branch is buffered
        tick();
        pc_i = 32'h3000; stall_i = 1'b1; br_req = 1'b1; br_tgt = 32'h3300;
        tick();
        br_req = 1'b0; jmp_req = 1'b1; jmp_tgt = 32'h3400;
        tick();
        idle();
        #1 chk_out("drop", 32'h3300, 1'b1, 1'b0, 1'b1, 1'b0);

        // misaligned branch target
        tick();
        br_req = 1'b1; br_tgt = 32'h3042;
        #1 chk_out("mis", 32'h4180, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle(); pc_i = 32'h4180;
        #1 chk_out("mis_fl", 32'h4184, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset while pending
        tick();
        pc_i = 32'h3000; stall_i = 1'b1; br_req = 1'b1; br_tgt = 32'h3500;
        tick();
        br_req = 1'b0;
        #1 chk_out("pre_rst", 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 reset = 1'b0;
        #1 chk_out("rst_pend", 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(); pc_i = 32'h0;
        #1 reset = 1'b1;
        #1 chk_out("reboot", 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        #1 chk_out("reboot_run", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/npc_sched.md
NPC_SCHED -- requirements
Module: npc_sched

Interface
REQ-001 SHALL have parameters: PC_RESET 32'h0000_3000, reset/boot PC; EXC_VEC 32'h0000_4180, exception entry PC.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard stall; PC must hold.
- pc_i  in  32  current PC register value.
- br_req/br_tgt  in  1/32  branch redirect and target.
- jmp_req/jmp_tgt  in  1/32  jump redirect and target.
- exc_req  in  1  exception request.
- eret_req/epc_i  in  1/32  exception return and return PC.
- npc_o  out  32  next PC value for the PC register.
- pc_we_o  out  1  PC register write enable.
- flush_o  out  1  kill the younger instruction in fetch/decode.
- pend_o  out  1  a redirect is buffered.
- misalign_o  out  1  the selected target is not word-aligned.
REQ-003 The clock and reset SHALL be named clk and reset; reset is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be BOOT, RUN, PEND and FLUSH.
REQ-005 Redirect priority SHALL be exc_req > eret_req > br_req > jmp_req; the winner's target is the selected target (exc uses EXC_VEC).
REQ-006 BOOT: pc_we_o=1, npc_o=PC_RESET, next state RUN; BOOT lasts exactly one cycle after reset release.
REQ-007 RUN, stall_i=0, no request: pc_we_o=1, npc_o=pc_i+4, computed mod 2^32 (32'hFFFF_FFFC -> 0).
REQ-008 RUN, stall_i=0, redirect present: pc_we_o=1, npc_o=selected target, same cycle (zero latency).
REQ-009 RUN, stall_i=1, no request: pc_we_o=0, npc_o=pc_i+4.
REQ-010 RUN, stall_i=1, redirect present: pc_we_o=0; latch target and priority into the pending buffer; next state PEND.
REQ-011 PEND: pend_o=1.
- Each further request is latched only if its priority is strictly higher than the buffered one; otherwise it is dropped.
- When stall_i=0: pc_we_o=1, npc_o=buffered target (or a same-cycle higher-priority request), then clear the buffer and go to RUN.
REQ-012 Exception (exc_req, or buffered exc) taking effect: flush_o=1 in that cycle; next state FLUSH.
REQ-013 FLUSH: pc_we_o=stall_i?0:1, npc_o=pc_i+4, flush_o=0; requests are handled as in RUN; next state RUN.
REQ-014 A selected target with [1:0]!=0 SHALL assert misalign_o (combinational) and be replaced by EXC_VEC, with exception semantics (REQ-012).
REQ-015 br_req and jmp_req in the same cycle: branch wins; the jump is discarded, not buffered.
REQ-016 Outputs SHALL be combinational from state, the buffer and inputs; no output depends on X when inputs are defined.

Reset
REQ-017 While reset=0: state=BOOT, buffer cleared, pc_we_o=0, flush_o=0, pend_o=0, misalign_o=0, npc_o=PC_RESET.
REQ-018 Reset asserted in PEND SHALL discard the buffered redirect immediately, without waiting for a clock edge.
REQ-019 All flops SHALL use only the asynchronous reset; no synchronous clear.

Structure
REQ-020 A shared package SHALL hold PC_RESET, EXC_VEC, the FSM state encoding and the 2-bit redirect-priority encoding (NONE=0, JMP=1, BR=2, ERET=3; exc kept as a separate flag).
REQ-021 One sub-module, npc_prio_sel (combinational priority select plus misalign check), SHALL be shared by the RUN and PEND paths.
REQ-022 Target size: 150-300 lines of RTL.

Verification
REQ-023 Release reset with pc_i=0 -> cycle 1: pc_we_o=1, npc_o=0x3000; cycle 2: npc_o=pc_i+4.
REQ-024 RUN, pc_i=0x3010, br_req=1, br_tgt=0x3040, stall_i=0 -> npc_o=0x3040, pc_we_o=1, pend_o=0.
REQ-025 stall_i=1 for 3 cycles; jmp_req (0x3100) in cycle 1, br_req (0x3200) in cycle 2 -> pend_o=1, pc_we_o=0; on release npc_o=0x3200.
REQ-026 stall_i=1, br buffered (0x3200), then exc_req -> on release npc_o=0x4180, flush_o=1, next cycle state FLUSH with flush_o=0.
REQ-027 br_tgt=0x3042 -> misalign_o=1, npc_o=0x4180, flush_o=1.
REQ-028 Assert reset while in PEND -> pend_o=0 and npc_o=0x3000 before the next clock edge; after release the BOOT cycle repeats.
